// File: rtl/mem_lsu_pkg.sv
// Shared constants, state encoding and request-legality helper for the MEM-stage load/store unit.
package mem_lsu_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned ADDR_WIDTH = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_LOAD_DONE   = 2'd1,
      ST_STORE_MERGE = 2'd2
   } state_e;

   // True when a request must be dropped with a misalign pulse instead of touching memory.
   function automatic logic is_illegal(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [1:0] lo);
      logic ill;
      ill = 1'b0;
      if (rd && wr) ill = 1'b1;
      if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
      if (wr && (f3 == F3_BU || f3 == F3_HU)) ill = 1'b1;
      if ((f3 == F3_H || f3 == F3_HU) && lo[0]) ill = 1'b1;
      if (f3 == F3_W && lo != 2'b00) ill = 1'b1;
      return ill;
   endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Word-wide data memory port between the load/store unit and the memory.
interface mem_lsu_if;
   import mem_lsu_pkg::*;

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
   modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane logic: load extract/extend and sub-word store merge into a full word.
module lsu_lane_align
   import mem_lsu_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] word_i,
   input  logic [1:0]            off_i,
   input  logic [2:0]            funct3_i,
   input  logic [DATA_WIDTH-1:0] sdata_i,
   output logic [DATA_WIDTH-1:0] load_o,
   output logic [DATA_WIDTH-1:0] merge_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[{off_i, 3'b000} +: 8];
      half_sel = word_i[{off_i[1], 4'b0000} +: 16];
      load_o   = word_i;
      unique case (funct3_i)
         F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_o = {24'd0, byte_sel};
         F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_o = {16'd0, half_sel};
         default: load_o = word_i;
      endcase
   end

   // Replace only the addressed lane(s) of the word read back from memory.
   always_comb begin
      merge_o = word_i;
      unique case (funct3_i)
         F3_B:    merge_o[{off_i, 3'b000} +: 8]     = sdata_i[7:0];
         F3_H:    merge_o[{off_i[1], 4'b0000} +: 16] = sdata_i[15:0];
         default: merge_o = sdata_i;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: word accesses, read-modify-write sub-word stores, pipeline stall.
module mem_lsu
   import mem_lsu_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  memread_m,
   input  logic                  memwrite_m,
   input  logic [2:0]            funct3_m,
   input  logic [ADDR_WIDTH-1:0] addr_m,
   input  logic [DATA_WIDTH-1:0] wdata_m,
   output logic                  stall_m,
   output logic                  load_valid_m,
   output logic [DATA_WIDTH-1:0] load_data_m,
   output logic                  misalign_m,
   mem_lsu_if.master             mem
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rword_q, rword_d;
   logic [DATA_WIDTH-1:0] load_ext;
   logic [DATA_WIDTH-1:0] store_merged;
   logic                  req;

   lsu_lane_align u_align (
      .word_i   (rword_q),
      .off_i    (addr_q[1:0]),
      .funct3_i (funct3_q),
      .sdata_i  (wdata_q),
      .load_o   (load_ext),
      .merge_o  (store_merged)
   );

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      funct3_d      = funct3_q;
      wdata_d       = wdata_q;
      rword_d       = rword_q;
      stall_m       = 1'b0;
      load_valid_m  = 1'b0;
      load_data_m   = '0;
      misalign_m    = 1'b0;
      mem.mem_addr  = {addr_m[ADDR_WIDTH-1:2], 2'b00};
      mem.mem_we    = 1'b0;
      mem.mem_wdata = '0;
      req           = memread_m | memwrite_m;

      unique case (state_q)
         ST_IDLE: begin
            if (req && is_illegal(memread_m, memwrite_m, funct3_m, addr_m[1:0])) begin
               misalign_m = 1'b1;
            end else if (req) begin
               addr_d   = addr_m;
               funct3_d = funct3_m;
               wdata_d  = wdata_m;
               if (memwrite_m && funct3_m == F3_W) begin
                  mem.mem_we    = 1'b1;
                  mem.mem_wdata = wdata_m;
               end else begin
                  // Loads and sub-word stores both need the current word first.
                  stall_m = 1'b1;
                  rword_d = mem.mem_rdata;
                  state_d = memread_m ? ST_LOAD_DONE : ST_STORE_MERGE;
               end
            end
         end
         ST_LOAD_DONE: begin
            mem.mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            load_valid_m = 1'b1;
            load_data_m  = load_ext;
            state_d      = ST_IDLE;
         end
         ST_STORE_MERGE: begin
            mem.mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            mem.mem_we    = 1'b1;
            mem.mem_wdata = store_merged;
            state_d       = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Reset silences every output in the same cycle, including an in-flight write.
      if (rst) begin
         stall_m       = 1'b0;
         load_valid_m  = 1'b0;
         load_data_m   = '0;
         misalign_m    = 1'b0;
         mem.mem_addr  = '0;
         mem.mem_we    = 1'b0;
         mem.mem_wdata = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         funct3_q <= '0;
         wdata_q  <= '0;
         rword_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         funct3_q <= funct3_d;
         wdata_q  <= wdata_d;
         rword_q  <= rword_d;
      end
   end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit in the MEM stage of the pipelined processor, acting as the initiator toward the word-wide data memory. It converts RISC-V-style byte, halfword and word loads and stores into word accesses on the memory port. Sub-word stores use a read-modify-write sequence, and the block stalls the pipeline while a multi-cycle access is in flight. It also flags misaligned or illegal accesses without touching memory.

## Interface
- DATA_WIDTH, 32: word width; the lane logic supports only 32.
- ADDR_WIDTH, 32: byte-address width.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- memread_m  in  1  load request this cycle.
- memwrite_m  in  1  store request this cycle.
- funct3_m  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores).
- addr_m  in  ADDR_WIDTH  byte address.
- wdata_m  in  DATA_WIDTH  store data, right-aligned.
- stall_m  out  1  hold the pipeline; the request inputs stay stable.
- load_valid_m  out  1  load_data_m valid this cycle.
- load_data_m  out  DATA_WIDTH  extracted, extended load result.
- misalign_m  out  1  one-cycle pulse: misaligned/illegal access dropped.
- mem_addr  out  ADDR_WIDTH  word address to memory, with [1:0] = 00.
- mem_we  out  1  memory write enable, sampled at posedge.
- mem_wdata  out  DATA_WIDTH  full word to write.
- mem_rdata  in  DATA_WIDTH  combinational read data for mem_addr.

## Operation
- FSM states: IDLE, LOAD_DONE, STORE_MERGE.
- Acceptance happens in IDLE only. The block latches addr, funct3 and wdata into _q registers on acceptance.
- **Illegal request:** any of the following is illegal:
  - memread_m and memwrite_m both high.
  - funct3 in {011, 110, 111}.
  - A store with funct3 of 100 or 101.
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠00.
  - An illegal request produces misalign_m=1 for that cycle, with no access, no stall, and the FSM stays in IDLE.
- **Word store:** in IDLE, mem_we=1 and mem_wdata=wdata_m in the same cycle. There is no stall and the FSM stays in IDLE.
- **Sub-word store:**
  - IDLE: stall_m=1 and mem_rdata is captured into rword_q. Transition to STORE_MERGE.
  - STORE_MERGE: mem_we=1 and mem_wdata=rword_q with the addressed lane(s) replaced by wdata_q[7:0] or [15:0]. stall_m=0. Transition to IDLE.
- **Load:**
  - IDLE: stall_m=1 and mem_rdata is captured into rword_q. Transition to LOAD_DONE.
  - LOAD_DONE: load_valid_m=1, stall_m=0, and load_data_m is the byte/half selected by addr_q[1:0]. B/H results are sign-extended; BU/HU results are zero-extended. Transition to IDLE.
- In IDLE with no request, or with an illegal request, all memory outputs are inactive: mem_we=0, and mem_addr follows addr_m with [1:0] zeroed.
- mem_addr is driven from addr_q in LOAD_DONE and STORE_MERGE.
- Requests presented while the FSM is not in IDLE are ignored; the stall guarantees they are the held request.

## Timing
- **Reset:** state=IDLE. stall_m, load_valid_m, misalign_m and mem_we are 0. load_data_m, mem_wdata and the _q registers are 0. mem_addr is 0.
- **Reset mid-operation:** reset in STORE_MERGE suppresses the write (mem_we=0 that cycle). Reset in LOAD_DONE suppresses load_valid_m.
- **Latencies:**
  - Word store: 1 cycle, 0 stall.
  - Sub-word store: 2 cycles, 1 stall cycle.
  - Load of any size: 2 cycles, 1 stall cycle.
  - Illegal request: misalign_m in the same cycle.
- stall_m is combinational from IDLE plus the request inputs. Its only dependency path is request → stall; there is no path from mem_rdata.
- Back-to-back requests: a new request may be accepted in the cycle immediately after LOAD_DONE or STORE_MERGE. The maximum rate is one load per 2 cycles.

## Structure
- **Package mem_lsu_pkg:** funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum/localparams.
- **Sub-module lsu_lane_align (combinational):** extract/extend for loads and lane merge for stores. Inputs are word, byte offset, funct3 and store data. It is instantiated once.
- mem_lsu holds only the FSM, the _q registers and the output muxing.

## Test plan
- Reset held for 3 cycles with requests asserted → all outputs 0, no mem_we.
- SW 0xDEADBEEF @0x10, then LW @0x10 → mem_we pulse at cycle 0 with addr 0x10. The load asserts stall for 1 cycle, then load_valid with 0xDEADBEEF.
- Memory word 0x80FF7F01 @0x20:
  - LB @0x22 → 0xFFFFFFFF.
  - LBU @0x23 → 0x00000080.
  - LH @0x22 → 0xFFFF80FF.
  - LHU @0x20 → 0x00007F01.
- Memory word 0x11223344 @0x30:
  - SB 0xAA @0x31 → stall 1 cycle, then write 0x1122AA44.
  - SH 0xBEEF @0x32 → word becomes 0xBEEFAA44.
- LW @0x05, SH @0x03, and memread+memwrite together → each produces a misalign_m pulse with no mem_we, no stall, and memory unchanged.
- SB @0x40 with rst asserted in STORE_MERGE → no write occurs, and the FSM is in IDLE on the next cycle.
